de_interlock_ctrl: RTL and testbench

Parametrised decode-stage interlock and forwarding controller for the 5-stage CPU. It keeps a scoreboard of in-flight destination registers across DEPTH downstream stages and computes the per-operand forwarding selects. It also generates the load-use stall and a configurable branch-bubble stall. It sits beside decode_stage and replaces that stage's fixed lw/branch stall and single-stage forward-address registers.

---
 rtl/de_interlock_ctrl.sv | 127 ++++++++++++
 tb/tb_de_interlock_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/de_interlock_ctrl.sv
// de_interlock_ctrl: decode-stage interlock and forwarding controller tracking in-flight destinations.
// Define DE_FWD_EN to enable forward selects; without it any RAW hazard stalls until the producer retires.
module de_interlock_ctrl #(
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned BR_BUBBLES = 3,
  parameter int unsigned SELW       = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            de_valid,
  input  logic [4:0]      de_rs,
  input  logic [4:0]      de_rt,
  input  logic            de_rs_used,
  input  logic            de_rt_used,
  input  logic [4:0]      de_dst,
  input  logic            de_wen,
  input  logic            de_is_load,
  input  logic            de_is_br,
  output logic            stall,
  output logic            de_issue,
  output logic [SELW-1:0] fwd_rs_sel,
  output logic [SELW-1:0] fwd_rt_sel
);

  localparam int unsigned RW    = 5;
  localparam int unsigned BCNTW = 4;

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] dst;
    logic          wen;
    logic          is_load;
  } sb_entry_t;

  sb_entry_t        sb_q [1:DEPTH];
  sb_entry_t        sb_d [1:DEPTH];
  logic [BCNTW-1:0] bcnt_q;
  logic [BCNTW-1:0] bcnt_d;

  logic [DEPTH:1]   rs_match;
  logic [DEPTH:1]   rt_match;
  logic             load_use;
  logic             raw_stall;
  logic [SELW-1:0]  rs_sel;
  logic [SELW-1:0]  rt_sel;

  // Per-stage operand hazard detection; r0 never hazards.
  always_comb begin
    rs_match = '0;
    rt_match = '0;
    for (int k = 1; k <= int'(DEPTH); k++) begin
      rs_match[k] = sb_q[k].valid & sb_q[k].wen & (sb_q[k].dst == de_rs) &
                    (de_rs != '0) & de_rs_used;
      rt_match[k] = sb_q[k].valid & sb_q[k].wen & (sb_q[k].dst == de_rt) &
                    (de_rt != '0) & de_rt_used;
    end
  end

  // A load whose data is not yet forwardable blocks its consumer.
  always_comb begin
    load_use = 1'b0;
    for (int k = 1; k <= int'(DEPTH); k++) begin
      if ((k < int'(LOAD_READY)) && sb_q[k].is_load && (rs_match[k] || rt_match[k])) begin
        load_use = 1'b1;
      end
    end
  end

`ifdef DE_FWD_EN
  // Walk from the oldest stage down so the youngest producer wins.
  always_comb begin
    rs_sel    = '0;
    rt_sel    = '0;
    raw_stall = 1'b0;
    for (int k = int'(DEPTH); k >= 1; k--) begin
      if (rs_match[k]) rs_sel = SELW'(k);
      if (rt_match[k]) rt_sel = SELW'(k);
    end
  end
`else
  always_comb begin
    rs_sel    = '0;
    rt_sel    = '0;
    raw_stall = (|rs_match) | (|rt_match);
  end
`endif

  assign fwd_rs_sel = rs_sel;
  assign fwd_rt_sel = rt_sel;
  assign stall      = (de_valid & (load_use | raw_stall)) | (bcnt_q != '0);
  assign de_issue   = de_valid & ~stall;

  // Scoreboard shift and branch-bubble counter next state.
  always_comb begin
    sb_d   = sb_q;
    bcnt_d = bcnt_q;
    if (de_issue) begin
      sb_d[1] = '{valid: 1'b1, dst: de_dst, wen: de_wen, is_load: de_is_load};
    end else begin
      sb_d[1] = '0;
    end
    for (int k = 2; k <= int'(DEPTH); k++) begin
      sb_d[k] = sb_q[k-1];
    end
    if (de_issue && de_is_br) begin
      bcnt_d = BCNTW'(BR_BUBBLES);
    end else if (bcnt_q != '0) begin
      bcnt_d = bcnt_q - BCNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 1; k <= int'(DEPTH); k++) begin
        sb_q[k] <= '0;
      end
      bcnt_q <= '0;
    end else begin
      for (int k = 1; k <= int'(DEPTH); k++) begin
        sb_q[k] <= sb_d[k];
      end
      bcnt_q <= bcnt_d;
    end
  end

endmodule

// File: tb/tb_de_interlock_ctrl.sv
// tb_de_interlock_ctrl: vector table plus hand sequences for de_interlock_ctrl (DEPTH=3, LOAD_READY=2).
`timescale 1ns/1ps
module tb_de_interlock_ctrl;

  localparam int unsigned DEPTH      = 3;
  localparam int unsigned LOAD_READY = 2;
  localparam int unsigned BR_BUBBLES = 3;
  localparam int unsigned SELW       = $clog2(DEPTH + 1);
`ifdef DE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk;
  logic            resetn;
  logic            de_valid;
  logic [4:0]      de_rs, de_rt, de_dst;
  logic            de_rs_used, de_rt_used, de_wen, de_is_load, de_is_br;
  logic            stall, de_issue;
  logic [SELW-1:0] fwd_rs_sel, fwd_rt_sel;
  logic            stall_b0, issue_b0;
  logic [SELW-1:0] rs_sel_b0, rt_sel_b0;

  de_interlock_ctrl #(.DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .BR_BUBBLES(BR_BUBBLES)) dut (
    .clk(clk), .resetn(resetn), .de_valid(de_valid), .de_rs(de_rs), .de_rt(de_rt),
    .de_rs_used(de_rs_used), .de_rt_used(de_rt_used), .de_dst(de_dst), .de_wen(de_wen),
    .de_is_load(de_is_load), .de_is_br(de_is_br), .stall(stall), .de_issue(de_issue),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel)
  );

  de_interlock_ctrl #(.DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .BR_BUBBLES(0)) dut_b0 (
    .clk(clk), .resetn(resetn), .de_valid(de_valid), .de_rs(de_rs), .de_rt(de_rt),
    .de_rs_used(de_rs_used), .de_rt_used(de_rt_used), .de_dst(de_dst), .de_wen(de_wen),
    .de_is_load(de_is_load), .de_is_br(de_is_br), .stall(stall_b0), .de_issue(issue_b0),
    .fwd_rs_sel(rs_sel_b0), .fwd_rt_sel(rt_sel_b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [4:0] rs; logic [4:0] rt; logic rsu; logic rtu;
    logic [4:0] dst; logic wen; logic ld; logic br;
    logic fs; logic fi; int frs; int frt;
    logic ns; logic ni;
  } vec_t;

  typedef struct {
    string name;
    logic  stall; logic issue; int rs; int rt;
    logic  chk_b0; logic b0_stall;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic v, int rs, int rt, logic rsu, logic rtu, int dst,
                              logic wen, logic ld, logic br, logic fs, logic fi,
                              int frs, int frt, logic ns, logic ni);
    vec_t r;
    r.v = v; r.rs = 5'(rs); r.rt = 5'(rt); r.rsu = rsu; r.rtu = rtu;
    r.dst = 5'(dst); r.wen = wen; r.ld = ld; r.br = br;
    r.fs = fs; r.fi = fi; r.frs = frs; r.frt = frt; r.ns = ns; r.ni = ni;
    return r;
  endfunction

  task automatic drive(input vec_t r);
    de_valid = r.v; de_rs = r.rs; de_rt = r.rt; de_rs_used = r.rsu; de_rt_used = r.rtu;
    de_dst = r.dst; de_wen = r.wen; de_is_load = r.ld; de_is_br = r.br;
  endtask

  task automatic push_exp(input string name, input logic s, input logic i, input int rs,
                          input int rt, input logic chk_b0, input logic b0s);
    exp_t e;
    e.name = name; e.stall = s; e.issue = i; e.rs = rs; e.rt = rt;
    e.chk_b0 = chk_b0; e.b0_stall = b0s;
    exp_q.push_back(e);
  endtask

  task automatic push_vec(input string name, input vec_t r);
    push_exp(name, FWD ? r.fs : r.ns, FWD ? r.fi : r.ni,
             FWD ? r.frs : 0, FWD ? r.frt : 0, 1'b0, 1'b0);
  endtask

  task automatic check();
    exp_t e;
    logic bad;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard: no expected entry queued at t=%0t", $time);
    end else begin
      e = exp_q.pop_front();
      bad = (stall !== e.stall) || (de_issue !== e.issue) ||
            (fwd_rs_sel !== SELW'(e.rs)) || (fwd_rt_sel !== SELW'(e.rt)) ||
            (e.chk_b0 && (stall_b0 !== e.b0_stall));
      if (bad) begin
        n_bad++;
        $display("FAIL %s: got stall=%0b issue=%0b rs_sel=%0d rt_sel=%0d b0_stall=%0b, want stall=%0b issue=%0b rs_sel=%0d rt_sel=%0d b0_stall=%0b(chk=%0b)",
                 e.name, stall, de_issue, fwd_rs_sel, fwd_rt_sel, stall_b0,
                 e.stall, e.issue, e.rs, e.rt, e.b0_stall, e.chk_b0);
      end
    end
  endtask

  task automatic idle3();
    for (int j = 0; j < 3; j++) tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0, 0,0));
  endtask

  task automatic step(input string name, input vec_t r);
    @(posedge clk); #1;
    drive(r);
    push_vec(name, r);
    @(negedge clk);
    check();
  endtask

  initial begin
    vec_t r;
    // ALU chain: add r3 then four reads of r3
    tbl.push_back(mk(1,0,0,0,0,3,1,0,0, 0,1,0,0, 0,1));
    tbl.push_back(mk(1,3,0,1,0,0,0,0,0, 0,1,1,0, 1,0));
    tbl.push_back(mk(1,3,0,1,0,0,0,0,0, 0,1,2,0, 1,0));
    tbl.push_back(mk(1,3,0,1,0,0,0,0,0, 0,1,3,0, 1,0));
    tbl.push_back(mk(1,3,0,1,0,0,0,0,0, 0,1,0,0, 0,1));
    idle3();
    // Load-use: lw r4, consumer reads r4 and r9 and writes r9
    tbl.push_back(mk(1,0,0,0,0,4,1,1,0, 0,1,0,0, 0,1));
    tbl.push_back(mk(1,9,4,1,1,9,1,0,0, 1,0,0,1, 1,0));
    tbl.push_back(mk(1,9,4,1,1,9,1,0,0, 0,1,0,2, 1,0));
    tbl.push_back(mk(1,9,4,1,1,9,1,0,0, 0,1,1,3, 1,0));
    tbl.push_back(mk(1,9,4,1,1,9,1,0,0, 0,1,1,0, 0,1));
    idle3();
    // Priority: two writers of r6, youngest wins
    tbl.push_back(mk(1,0,0,0,0,6,1,0,0, 0,1,0,0, 0,1));
    tbl.push_back(mk(1,0,0,0,0,6,1,0,0, 0,1,0,0, 0,1));
    tbl.push_back(mk(1,6,0,1,0,0,0,0,0, 0,1,1,0, 1,0));
    idle3();
    // r0 never forwards nor stalls
    tbl.push_back(mk(1,0,0,0,0,0,1,0,0, 0,1,0,0, 0,1));
    tbl.push_back(mk(1,0,0,1,1,0,0,0,0, 0,1,0,0, 0,1));
    idle3();
    // Branch: three bubbles, no entries created while stalled
    tbl.push_back(mk(1,0,0,0,0,0,0,0,1, 0,1,0,0, 0,1));
    for (int j = 0; j < 3; j++) tbl.push_back(mk(1,0,0,0,0,5,1,0,0, 1,0,0,0, 1,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 0,1,0,0, 0,1));
    tbl.push_back(mk(1,5,0,1,0,0,0,0,0, 0,1,0,0, 0,1));
    idle3();
    // Branch held by load-use loads bcnt only when it issues
    tbl.push_back(mk(1,0,0,0,0,8,1,1,0, 0,1,0,0, 0,1));
    tbl.push_back(mk(1,8,0,1,0,0,0,0,1, 1,0,1,0, 1,0));
    tbl.push_back(mk(1,8,0,1,0,0,0,0,1, 0,1,2,0, 1,0));
    for (int j = 0; j < 3; j++) tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,0,0,0, 0,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 0,1,0,0, 0,1));
    idle3();

    // Reset state
    resetn = 1'b0;
    drive(mk(1,5,0,1,0,0,0,0,0, 0,0,0,0, 0,0));
    #2;
    push_exp("reset_state", 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    check();
    drive(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0, 0,0));
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("vec%0d", i), tbl[i]);
    end

    // Mid-stream reset with bcnt=2 and add r5 sitting in stage 3
    step("rst_add",  mk(1,0,0,0,0,5,1,0,0, 0,1,0,0, 0,1));
    step("rst_beq",  mk(1,0,0,0,0,0,0,0,1, 0,1,0,0, 0,1));
    step("rst_bub1", mk(1,0,0,0,0,0,0,0,0, 1,0,0,0, 1,0));
    step("rst_pre",  mk(1,5,0,1,0,0,0,0,0, 1,0,3,0, 1,0));
    #2;
    resetn = 1'b0;
    #1;
    push_exp("rst_async", 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    check();
    @(negedge clk);
    resetn = 1'b1;
    step("rst_after1", mk(1,5,0,1,0,0,0,0,0, 0,1,0,0, 0,1));
    step("rst_after2", mk(1,5,0,1,0,0,0,0,0, 0,1,0,0, 0,1));
    for (int j = 0; j < 3; j++) step($sformatf("drain%0d", j), mk(0,0,0,0,0,0,0,0,0, 0,0,0,0, 0,0));

    // Zero-bubble build never stalls on a branch
    r = mk(1,0,0,0,0,0,0,0,1, 0,1,0,0, 0,1);
    @(posedge clk); #1; drive(r);
    push_exp("b0_br", 1'b0, 1'b1, 0, 0, 1'b1, 1'b0);
    @(negedge clk); check();
    r = mk(1,0,0,0,0,0,0,0,0, 0,0,0,0, 0,0);
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1; drive(r);
      push_exp($sformatf("b0_bub%0d", j), 1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
      @(negedge clk); check();
    end
    @(posedge clk); #1; drive(r);
    push_exp("b0_end", 1'b0, 1'b1, 0, 0, 1'b1, 1'b0);
    @(negedge clk); check();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
